// File: rtl/pwm_level_ramp_pkg.sv
// Shared definitions for the multi-channel PWM level ramp: defaults, channel slicing
// and the saturating step-toward-goal rule.
package pwm_level_ramp_pkg;

  localparam int unsigned PWM_WIDTH_DEFAULT = 8;
  localparam int unsigned RAMP_DIV_DEFAULT  = 16;
  localparam int unsigned CHANNELS_DEFAULT  = 2;

  // Low bit index of channel k inside a flat CHANNELS*width bus.
  function automatic int unsigned ch_lo(int unsigned k, int unsigned width);
    return k * width;
  endfunction

  // Move cur toward goal by at most step, never overshooting; differences avoid overflow.
  function automatic int unsigned step_toward(int unsigned cur, int unsigned goal,
                                              int unsigned step);
    if (cur < goal) begin
      return (goal - cur > step) ? cur + step : goal;
    end else if (cur > goal) begin
      return (cur - goal > step) ? cur - step : goal;
    end
    return cur;
  endfunction

endpackage

// File: rtl/pwm_level_ramp_if.sv
// Control/status bundle between the level-control block (master) and the PWM ramp (slave).
interface pwm_level_ramp_if
  import pwm_level_ramp_pkg::*;
#(
  parameter int unsigned WIDTH    = PWM_WIDTH_DEFAULT,
  parameter int unsigned CHANNELS = CHANNELS_DEFAULT
);

  logic [CHANNELS-1:0]       enable;
  logic [CHANNELS*WIDTH-1:0] target;
  logic [CHANNELS-1:0]       pwm_out;
  logic [CHANNELS*WIDTH-1:0] current;
  logic [CHANNELS-1:0]       at_target;
  logic                      period_strobe;

  modport master (
    output enable, target,
    input  pwm_out, current, at_target, period_strobe
  );

  modport slave (
    input  enable, target,
    output pwm_out, current, at_target, period_strobe
  );

endinterface

// File: rtl/pwm_level_channel.sv
// One PWM level channel: goal capture at period boundaries, stepped duty and compare output.
module pwm_level_channel
  import pwm_level_ramp_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH_DEFAULT,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             boundary_i,
  input  logic             step_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] target_i,
  output logic             pwm_o,
  output logic [WIDTH-1:0] current_o,
  output logic             at_target_o
);

  logic [WIDTH-1:0] current_q, current_d;
  logic [WIDTH-1:0] goal_q, goal_d;
  logic             pwm_q;
  logic             at_target_q;

  always_comb begin
    goal_d    = goal_q;
    current_d = current_q;
    // Goal is only observed at the boundary edge, so mid-period input changes are ignored.
    if (boundary_i) begin
      goal_d = enable_i ? target_i : '0;
    end
    if (step_i) begin
      current_d = WIDTH'(step_toward(32'(current_q), 32'(goal_d), STEP));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      current_q   <= '0;
      goal_q      <= '0;
      pwm_q       <= 1'b0;
      at_target_q <= 1'b1;
    end else begin
      current_q   <= current_d;
      goal_q      <= goal_d;
      pwm_q       <= (cnt_i < current_q);
      at_target_q <= (current_d == goal_d);
    end
  end

  assign pwm_o       = pwm_q;
  assign current_o   = current_q;
  assign at_target_o = at_target_q;

endmodule

// File: rtl/pwm_level_ramp.sv
// Multi-channel TX level PWM: shared period counter and ramp divider feeding per-channel
// stepped-duty generators.
module pwm_level_ramp
  import pwm_level_ramp_pkg::*;
#(
  parameter int unsigned WIDTH    = PWM_WIDTH_DEFAULT,
  parameter int unsigned CHANNELS = CHANNELS_DEFAULT,
  parameter int unsigned RAMP_DIV = RAMP_DIV_DEFAULT,
  parameter int unsigned STEP     = 1
) (
  input logic               clock,
  input logic               nRES,
  pwm_level_ramp_if.slave   bus
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]       pdiv_q, pdiv_d;
  logic             strobe_q;
  logic             boundary;
  logic             step_now;

  logic [CHANNELS-1:0]       pwm_w;
  logic [CHANNELS-1:0]       at_target_w;
  logic [CHANNELS*WIDTH-1:0] current_w;

  always_comb begin
    boundary = (cnt_q == '1);
    step_now = boundary && (pdiv_q == 8'(RAMP_DIV - 1));
    cnt_d    = cnt_q + 1'b1;
    pdiv_d   = pdiv_q;
    if (boundary) begin
      pdiv_d = step_now ? 8'd0 : pdiv_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge nRES) begin
    if (!nRES) begin
      cnt_q    <= '0;
      pdiv_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pdiv_q   <= pdiv_d;
      // The boundary edge is the one that lands cnt on 0.
      strobe_q <= boundary;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    pwm_level_channel #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_channel (
      .clk_i       (clock),
      .rst_ni      (nRES),
      .cnt_i       (cnt_q),
      .boundary_i  (boundary),
      .step_i      (step_now),
      .enable_i    (bus.enable[k]),
      .target_i    (bus.target[ch_lo(k, WIDTH) +: WIDTH]),
      .pwm_o       (pwm_w[k]),
      .current_o   (current_w[ch_lo(k, WIDTH) +: WIDTH]),
      .at_target_o (at_target_w[k])
    );
  end

  assign bus.pwm_out       = pwm_w;
  assign bus.current       = current_w;
  assign bus.at_target     = at_target_w;
  assign bus.period_strobe = strobe_q;

endmodule
